// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory line arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PORT_D  = 0;
    localparam int unsigned PORT_I  = 1;

    // One-hot grant vector for a port index
    function automatic logic [NUM_REQ-1:0] port_onehot(input logic port);
        return NUM_REQ'(1) << port;
    endfunction

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Cache-request / memory-port bundle for mem_line_arbiter; master = arbiter side.
interface mem_line_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_W        = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_we;
    logic [ADDR_W-1:0]        req_addr0;
    logic [ADDR_W-1:0]        req_addr1;
    logic [DATA_W-1:0]        req_wdata0;
    logic [DATA_W-1:0]        req_wdata1;
    logic [NUM_REQ-1:0]       grant;
    logic [LINE_ADDR_LEN-1:0] word_idx;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_valid;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     mem_ack;

    modport master (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  mem_rdata, mem_ack,
        output grant, word_idx, rd_data, rd_valid, done, busy,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output mem_rdata, mem_ack,
        input  grant, word_idx, rd_data, rd_valid, done, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner select between the two line requesters.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise port 0 has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
`ifdef MEM_ARB_RR_EN
    input  logic               last_win,
`endif
    output logic               winner_c
);

`ifdef MEM_ARB_RR_EN
    // Tie goes to the port that did not win last time
    assign winner_c = (&req_valid) ? ~last_win : (req_valid[1] & ~req_valid[0]);
`else
    assign winner_c = req_valid[1] & ~req_valid[0];
`endif

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one word-wide memory port between the data and instruction caches, one line burst per grant.
// Build option: MEM_ARB_RR_EN enables round-robin tie-breaking (default fixed priority, port 0).
module mem_line_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_line_arbiter_if.master bus
);

    localparam int unsigned OFF_W = LINE_ADDR_LEN + 2;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [LINE_ADDR_LEN-1:0] LAST_IDX = '1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_XFER = XFER;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [NUM_REQ-1:0]       grant_q;
    logic [NUM_REQ-1:0]       done_q;
    logic [LINE_ADDR_LEN-1:0] idx_q;
    logic [ADDR_W-1:0]        base_q;
    logic                     we_q;
    logic                     busy_q;
    logic                     mem_req_q;
    logic                     winner_c;
    logic                     ack_c;
    logic                     start_c;
    logic [ADDR_W-1:0]        win_addr_c;

    assign ack_c      = mem_req_q & bus.mem_ack;
    assign start_c    = (state == ST_IDLE) && (|bus.req_valid);
    assign win_addr_c = winner_c ? bus.req_addr1 : bus.req_addr0;

`ifdef MEM_ARB_RR_EN
    logic last_win_q;

    arb_pick u_pick (
        .req_valid (bus.req_valid),
        .last_win  (last_win_q),
        .winner_c  (winner_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          last_win_q <= 1'b1;
        else if (start_c) last_win_q <= winner_c;
    end
`else
    arb_pick u_pick (
        .req_valid (bus.req_valid),
        .winner_c  (winner_c)
    );
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|bus.req_valid) state_nxt = ST_XFER;
            ST_XFER: if (ack_c && (idx_q == LAST_IDX)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            idx_q     <= '0;
            base_q    <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy_q    <= (state_nxt != ST_IDLE);
            mem_req_q <= (state_nxt == ST_XFER);
            done_q    <= (state_nxt == ST_DONE) ? grant_q : '0;
            if (start_c) begin
                grant_q <= port_onehot(winner_c);
                base_q  <= win_addr_c & ALIGN_MASK;
                we_q    <= bus.req_we[winner_c];
            end else if (state == ST_DONE) begin
                grant_q <= '0;
            end
            // Index wraps to 0 naturally after the last word
            if (ack_c) idx_q <= idx_q + LINE_ADDR_LEN'(1);
        end
    end

    assign bus.grant     = grant_q;
    assign bus.word_idx  = idx_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_req_q & we_q;
    assign bus.mem_addr  = base_q + ADDR_W'({idx_q, 2'b00});
    assign bus.mem_wdata = grant_q[PORT_I] ? bus.req_wdata1 : bus.req_wdata0;
    assign bus.rd_data   = bus.mem_rdata;
    assign bus.rd_valid  = ack_c & ~we_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter: bursts pushed when requests are raised, checked per memory word.
module tb_mem_line_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned LAL   = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned WORDS = 8;

    typedef struct {
        logic [1:0]  grant;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  idx;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_line_arbiter_if #(.LINE_ADDR_LEN(LAL), .ADDR_W(AW)) mif ();

    mem_line_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    word_t      exp_q[$];
    logic [1:0] done_q[$];
    word_t      mon_w;
    int         checks = 0;
    int         errors = 0;
    int         lat = 2;
    bit         ack_always = 1'b0;
    int         wait_cnt = 0;
    bit         prev_done = 1'b0;
    int         rdv_cnt = 0;
    logic       mdl_last = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always_comb begin
        mif.req_wdata0 = 32'h5000 + 32'(mif.word_idx);
        mif.req_wdata1 = 32'hA0 + 32'(mif.word_idx);
    end

    // Memory model, then monitor one unit later
    always @(negedge clk) begin
        if (rst || !mif.mem_req) begin
            mif.mem_ack = ack_always;
            wait_cnt = 0;
        end else if (ack_always || (wait_cnt + 1 >= lat)) begin
            mif.mem_ack = 1'b1;
            wait_cnt = 0;
        end else begin
            mif.mem_ack = 1'b0;
            wait_cnt++;
        end
        mif.mem_rdata = mem_word(mif.mem_addr);
        #1;
        if (!rst) begin
            if (prev_done) begin
                chk("gap_grant", 32'(mif.grant), 32'd0);
                chk("gap_busy", 32'(mif.busy), 32'd0);
            end
            prev_done = (mif.done != 2'b00);
            if (mif.rd_valid) rdv_cnt++;
            if (mif.mem_req && mif.mem_ack) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("grant", 32'(mif.grant), 32'(mon_w.grant));
                    chk("mem_we", 32'(mif.mem_we), 32'(mon_w.we));
                    chk("mem_addr", mif.mem_addr, mon_w.addr);
                    chk("word_idx", 32'(mif.word_idx), 32'(mon_w.idx));
                    chk("rd_valid", 32'(mif.rd_valid), 32'(!mon_w.we));
                    if (mon_w.we) chk("mem_wdata", mif.mem_wdata, mon_w.data);
                    else          chk("rd_data", mif.rd_data, mon_w.data);
                end
            end else if (mif.rd_valid) begin
                chk("spur_rd_valid", 32'(mif.rd_valid), 32'd0);
            end
            if (mif.done != 2'b00) begin
                if (done_q.size() == 0) chk("extra_done", 32'(mif.done), 32'd0);
                else                    chk("done", 32'(mif.done), 32'(done_q.pop_front()));
            end
        end
    end

    task automatic raise(input int p, input logic we, input logic [31:0] addr);
        mif.req_valid[p] = 1'b1;
        mif.req_we[p]    = we;
        if (p == 1) mif.req_addr1 = addr;
        else        mif.req_addr0 = addr;
    endtask

    task automatic push_burst(input int p, input logic we, input logic [31:0] addr);
        word_t w;
        logic [31:0] base;
        base = addr & ~32'h1F;
        for (int i = 0; i < int'(WORDS); i++) begin
            w.grant = (p == 1) ? 2'b10 : 2'b01;
            w.we    = we;
            w.addr  = base + 32'(4 * i);
            w.idx   = 3'(i);
            if (we) w.data = (p == 1) ? 32'hA0 + 32'(i) : 32'h5000 + 32'(i);
            else    w.data = mem_word(base + 32'(4 * i));
            exp_q.push_back(w);
        end
        done_q.push_back((p == 1) ? 2'b10 : 2'b01);
        mdl_last = (p == 1);
    endtask

    task automatic wait_done(input logic [1:0] mask, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk); #2;
            cyc++;
            if ((mif.done & mask) != 2'b00) seen = 1'b1;
        end
        if (!seen) chk("done_wait", 32'(mif.done), 32'(mask));
    endtask

    task automatic wait_idx(input logic [2:0] t);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk); #2;
            if (mif.busy && mif.word_idx == t) seen = 1'b1;
        end
        if (!seen) chk("idx_wait", 32'(mif.word_idx), 32'(t));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    function automatic int rr_pick();
`ifdef MEM_ARB_RR_EN
        return (mdl_last == 1'b0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic check_quiet(input string pfx);
        chk({pfx, "_grant"}, 32'(mif.grant), 32'd0);
        chk({pfx, "_idx"}, 32'(mif.word_idx), 32'd0);
        chk({pfx, "_done"}, 32'(mif.done), 32'd0);
        chk({pfx, "_busy"}, 32'(mif.busy), 32'd0);
        chk({pfx, "_mem_req"}, 32'(mif.mem_req), 32'd0);
        chk({pfx, "_mem_we"}, 32'(mif.mem_we), 32'd0);
        chk({pfx, "_rd_valid"}, 32'(mif.rd_valid), 32'd0);
    endtask

    initial begin
        int c;
        int rdv0;
        int w;
        rst = 1'b1;
        mif.req_valid = 2'b00;
        mif.req_we    = 2'b00;
        mif.req_addr0 = '0;
        mif.req_addr1 = '0;
        idle(3);
        check_quiet("reset");
        rst = 1'b0;
        idle(2);

        // Port 0 refill, 2-cycle memory latency
        rdv0 = rdv_cnt;
        raise(0, 1'b0, 32'h0000_1234);
        push_burst(0, 1'b0, 32'h0000_1234);
        wait_done(2'b01, c);
        mif.req_valid[0] = 1'b0;
        idle(2);
        chk("t1_rd_pulses", 32'(rdv_cnt - rdv0), 32'd8);

        // Port 1 write-back
        rdv0 = rdv_cnt;
        raise(1, 1'b1, 32'h0000_0040);
        push_burst(1, 1'b1, 32'h0000_0040);
        wait_done(2'b10, c);
        mif.req_valid[1] = 1'b0;
        idle(2);
        chk("t2_rd_pulses", 32'(rdv_cnt - rdv0), 32'd0);

        // Simultaneous requests, loser withdraws after the winner finishes
        for (int r = 0; r < 3; r++) begin
            raise(0, 1'b0, 32'h0000_1000 + 32'(r * 256));
            raise(1, 1'b0, 32'h0000_8000 + 32'(r * 256));
            w = rr_pick();
            push_burst(w, 1'b0, (w == 1) ? 32'h0000_8000 + 32'(r * 256) : 32'h0000_1000 + 32'(r * 256));
            wait_done((w == 1) ? 2'b10 : 2'b01, c);
            mif.req_valid = 2'b00;
            idle(2);
        end

        // Port 1 arrives mid-burst and waits its turn
        raise(0, 1'b0, 32'h0000_2000);
        push_burst(0, 1'b0, 32'h0000_2000);
        wait_idx(3'd2);
        raise(1, 1'b0, 32'h0000_3000);
        push_burst(1, 1'b0, 32'h0000_3000);
        wait_done(2'b01, c);
        mif.req_valid[0] = 1'b0;
        wait_done(2'b10, c);
        mif.req_valid[1] = 1'b0;
        idle(2);

        // Reset mid-burst after word 3
        raise(0, 1'b0, 32'h0000_4000);
        push_burst(0, 1'b0, 32'h0000_4000);
        wait_idx(3'd4);
        rst = 1'b1;
        #1;
        check_quiet("midrst");
        exp_q.delete();
        done_q.delete();
        mif.req_valid = 2'b00;
        mdl_last = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        raise(0, 1'b0, 32'h0000_4000);
        push_burst(0, 1'b0, 32'h0000_4000);
        wait_done(2'b01, c);
        mif.req_valid[0] = 1'b0;
        idle(2);

        // Zero-wait memory: line completes in 10 cycles IDLE to IDLE
        ack_always = 1'b1;
        raise(0, 1'b0, 32'h0000_6000);
        push_burst(0, 1'b0, 32'h0000_6000);
        wait_done(2'b01, c);
        mif.req_valid[0] = 1'b0;
        chk("line_cycles", 32'(c + 1), 32'd10);
        idle(3);
        ack_always = 1'b0;
        idle(2);

        chk("sb_words_left", 32'(exp_q.size()), 32'd0);
        chk("sb_done_left", 32'(done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
